fft_input: RTL and testbench
============================

# fft_input

Input-side loader for the FFT core: accepts a serial stream of `N` time-domain samples over a valid/ready handshake and writes them into the FFT sample memory two at a time. Each sample pair goes out through a dual write port, with addresses in bit-reversed order so the butterfly stages can run in place. It is the write-side counterpart of the FFT output unloader, and shares the same pairwise memory port shape: two addresses and two samples per access.

## Interface
- `N`, 32: FFT length; power of two, at least 4.
- `word_size`, 16: sample width in bits.
- `address_width`, `$clog2(N)`: memory address width.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  arm/run; low aborts and returns to IDLE.
- `in_valid`  in  1  `in_samp` is valid this cycle.
- `in_samp`  in  word_size  incoming sample.
- `in_ready`  out  1  loader can accept a sample.
- `wr_en`  out  1  one-cycle write strobe to sample memory.
- `wr_addr1`, `wr_addr2`  out  address_width  write addresses for even and odd sample of the pair.
- `wr_samp1`, `wr_samp2`  out  word_size  even and odd sample data.
- `done`  out  1  all `N` samples written; held until `en` low or reset.

## Operation
- One clock; reset is asynchronous and active-low.
- **Sample index.** `idx` runs from 0 to N-1 and counts accepted samples. It is an `address_width`-bit counter.
- **Accept rule.** A sample is accepted when `in_valid & in_ready` at the rising edge.
- **States:**
  - IDLE: `in_ready`=0, `idx`=0. Moves to EVEN when `en`=1.
  - EVEN: `in_ready`=1. On accept, latch the sample into the hold register, `idx`+1, move to ODD.
  - ODD: `in_ready`=1. On accept, issue the write for the pair, `idx`+1.
    - If the accepted sample was `idx`=N-1, move to DONE.
    - Otherwise, move to EVEN.
  - DONE: `in_ready`=0, `done`=1. Any `in_valid` is ignored. Moves to IDLE when `en`=0.
- **Abort.** `en`=0 in EVEN or ODD moves to IDLE next edge.
  - `idx` clears.
  - A latched half-pair is discarded; no write is issued.
  - `en`=0 has priority over a simultaneous accept.
- **Write data.** `wr_samp1` is the held even sample (index 2k). `wr_samp2` is the odd sample just accepted (index 2k+1).
- **Addresses.** `a1` = rev(2k) and `a2` = rev(2k+1) = rev(2k) + N/2, where rev is bit reversal over `address_width` bits.
- **Counter wrap.** `idx` wraps to 0 only through IDLE, never by overflow.

## Timing
- **Reset values.** `in_ready`, `wr_en`, `done`, `wr_addr1`, `wr_addr2`, `wr_samp1`, `wr_samp2` are all 0. State is IDLE, `idx`=0.
- **Registered outputs.** All outputs are registered.
- **Write latency.** `wr_en` pulses high for exactly one cycle, on the edge that accepts the odd sample. Address and data are valid in that same cycle.
- **Throughput.** One sample per cycle when `in_valid` is held high; no bubbles. An N-sample load takes N cycles after EVEN is entered.
- **Done timing.** `done` rises on the same edge as the final `wr_en` pulse. `in_ready` falls on that same edge.
- **Back-pressure.** Gaps in `in_valid` stall the loader without losing the held sample.
- **Mid-operation reset.** Asserting `reset_n` low immediately forces all outputs to their reset values, without waiting for a clock edge.

## Configuration
- **Macro `FFT_INPUT_BITREV_EN`.**
  - Defined: write addresses are bit-reversed as described under Operation.
  - Undefined: natural order, `wr_addr1`=2k and `wr_addr2`=2k+1. For use with a core that performs its own reordering.
  - All other behaviour is identical in both builds.

## Test plan
- **Bit-reversed load.** N=8, bit-reverse build, samples 10..17 back-to-back → four `wr_en` pulses on consecutive odd-sample cycles:
  - (0,4)=(10,11)
  - (2,6)=(12,13)
  - (1,5)=(14,15)
  - (3,7)=(16,17)
  - `done`=1 with the 4th pulse, `in_ready`=0 after.
- **Natural-order load.** Same stimulus, macro undefined → writes (0,1), (2,3), (4,5), (6,7) with the same data.
- **Gapped input.** `in_valid` toggles 1,0,0,1,… → same writes as the back-to-back case; hold value unchanged across gaps; no extra `wr_en` pulses.
- **Abort mid-pair.** `en`=0 after 3 samples → no write for sample 3 and state returns to IDLE. Re-arming and sending 8 samples then gives the first write at (0,4) with the new data.
- **Ignored input in DONE.** `in_valid`=1 held in DONE → no `wr_en`, `done` stays 1. Dropping `en` clears `done` next edge.
- **Async reset.** `reset_n` pulsed low between clock edges mid-load → outputs clear immediately. After release and `en`=1, a full load completes correctly from index 0.

Source files
------------

// File: rtl/fft_input_if.sv
// Stream-in / pairwise-write bundle for the FFT input loader.
// slave  : the loader side (consumes the sample stream, drives the memory write port).
// master : the producer / memory side.
interface fft_input_if #(
  parameter int word_size     = 16,
  parameter int address_width = 5
);
  logic                     in_valid;
  logic [word_size-1:0]     in_samp;
  logic                     in_ready;
  logic                     wr_en;
  logic [address_width-1:0] wr_addr1;
  logic [address_width-1:0] wr_addr2;
  logic [word_size-1:0]     wr_samp1;
  logic [word_size-1:0]     wr_samp2;

  modport slave (
    input  in_valid, in_samp,
    output in_ready, wr_en, wr_addr1, wr_addr2, wr_samp1, wr_samp2
  );

  modport master (
    output in_valid, in_samp,
    input  in_ready, wr_en, wr_addr1, wr_addr2, wr_samp1, wr_samp2
  );
endinterface

// File: rtl/fft_input.sv
// FFT input loader: takes N serial samples over valid/ready and writes them
// into sample memory as (even, odd) pairs with one write strobe per pair.
// Build option FFT_INPUT_BITREV_EN: defined -> bit-reversed write addresses,
// undefined -> natural order addresses.
//
// state | meaning
// IDLE  | not armed, index cleared, not ready
// EVEN  | waiting for the even sample of a pair
// ODD   | even sample held, waiting for the odd sample (write on accept)
// DONE  | all N samples written, input ignored until en drops
module fft_input #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic        done,
  fft_input_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;

  localparam logic [address_width-1:0] LAST_IDX = address_width'(N - 1);

  state_t                   r_state, w_state_nxt;
  logic [address_width-1:0] r_idx, w_idx_nxt;
  logic [word_size-1:0]     r_hold, w_hold_nxt;
  logic                     r_in_ready, w_in_ready_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_wr_en, w_wr_en_nxt;
  logic [address_width-1:0] r_addr1, w_addr1_nxt;
  logic [address_width-1:0] r_addr2, w_addr2_nxt;
  logic [word_size-1:0]     r_samp1, w_samp1_nxt;
  logic [word_size-1:0]     r_samp2, w_samp2_nxt;
  logic                     w_accept;
  logic [address_width-1:0] w_a1;
  logic [address_width-1:0] w_a2;

  function automatic logic [address_width-1:0] f_rev(input logic [address_width-1:0] a);
    logic [address_width-1:0] r;
    for (int i = 0; i < address_width; i++) r[i] = a[address_width-1-i];
    return r;
  endfunction

  // In ODD, r_idx is 2k+1; the even partner always differs only in the LSB
  // of the index, which after reversal is the MSB of the address.
`ifdef FFT_INPUT_BITREV_EN
  assign w_a2 = f_rev(r_idx);
  assign w_a1 = {1'b0, w_a2[address_width-2:0]};
`else
  assign w_a2 = r_idx;
  assign w_a1 = {r_idx[address_width-1:1], 1'b0};
`endif

  // in_ready is registered and high exactly in EVEN/ODD, so it qualifies the accept.
  assign w_accept = bus.in_valid & r_in_ready;

  // Next-state, counter, hold register and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_wr_en_nxt = 1'b0;
    w_addr1_nxt = r_addr1;
    w_addr2_nxt = r_addr2;
    w_samp1_nxt = r_samp1;
    w_samp2_nxt = r_samp2;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        if (en) w_state_nxt = EVEN;
      end
      EVEN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (w_accept) begin
          w_hold_nxt  = bus.in_samp;
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = ODD;
        end
      end
      ODD: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (w_accept) begin
          w_wr_en_nxt = 1'b1;
          w_addr1_nxt = w_a1;
          w_addr2_nxt = w_a2;
          w_samp1_nxt = r_hold;
          w_samp2_nxt = bus.in_samp;
          // Final index holds in DONE; it only returns to 0 via IDLE.
          if (r_idx == LAST_IDX) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = EVEN;
          end
        end
      end
      DONE: begin
        if (!en) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_in_ready_nxt = (w_state_nxt == EVEN) || (w_state_nxt == ODD);
    w_done_nxt     = (w_state_nxt == DONE);
  end

  // State, datapath and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_hold     <= '0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr1    <= '0;
      r_addr2    <= '0;
      r_samp1    <= '0;
      r_samp2    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_hold     <= w_hold_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_done     <= w_done_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_addr1    <= w_addr1_nxt;
      r_addr2    <= w_addr2_nxt;
      r_samp1    <= w_samp1_nxt;
      r_samp2    <= w_samp2_nxt;
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr1 = r_addr1;
  assign bus.wr_addr2 = r_addr2;
  assign bus.wr_samp1 = r_samp1;
  assign bus.wr_samp2 = r_samp2;
  assign done         = r_done;

endmodule

// File: tb/tb_fft_input.sv
// Bench for fft_input (N=8): directed load scenarios plus random traffic,
// checked every cycle against a sample-count / pair-list reference model.
module tb_fft_input;
  localparam int N  = 8;
  localparam int WS = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic done;

  fft_input_if #(.word_size(WS), .address_width(AW)) bus ();

  fft_input #(.N(N), .word_size(WS), .address_width(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 = not armed, 1 = loading, 2 = all N written.
  int            m_mode;
  logic [WS-1:0] m_q[$];
  logic          e_ready, e_done, e_wr;
  int            e_a1, e_a2;
  logic [WS-1:0] e_d1, e_d2;

  function automatic int mem_addr(input int i);
    int r;
`ifdef FFT_INPUT_BITREV_EN
    r = 0;
    for (int b = 0; b < AW; b++)
      if (((i >> b) & 1) == 1) r += (1 << (AW - 1 - b));
`else
    r = i;
`endif
    return r;
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_q.delete();
    e_ready = 0; e_done = 0; e_wr = 0;
    e_a1 = 0; e_a2 = 0; e_d1 = 0; e_d2 = 0;
  endtask

  task automatic m_edge(input logic v_en, input logic v_valid, input logic [WS-1:0] v_samp);
    int c;
    e_wr = 0;
    if (!reset_n) begin
      m_reset();
      return;
    end
    case (m_mode)
      0: if (v_en) begin m_mode = 1; m_q.delete(); end
      1: begin
        if (!v_en) begin
          m_mode = 0;
          m_q.delete();
        end else if (v_valid) begin
          m_q.push_back(v_samp);
          c = m_q.size();
          if (c % 2 == 0) begin
            e_wr = 1;
            e_a1 = mem_addr(c - 2);
            e_a2 = mem_addr(c - 1);
            e_d1 = m_q[c-2];
            e_d2 = m_q[c-1];
          end
          if (c == N) m_mode = 2;
        end
      end
      default: if (!v_en) m_mode = 0;
    endcase
    e_ready = (m_mode == 1);
    e_done  = (m_mode == 2);
  endtask

  task automatic check_all();
    chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
    chk("done",     32'(done),         32'(e_done));
    chk("wr_en",    32'(bus.wr_en),    32'(e_wr));
    chk("wr_addr1", 32'(bus.wr_addr1), 32'(e_a1));
    chk("wr_addr2", 32'(bus.wr_addr2), 32'(e_a2));
    chk("wr_samp1", 32'(bus.wr_samp1), 32'(e_d1));
    chk("wr_samp2", 32'(bus.wr_samp2), 32'(e_d2));
  endtask

  // Drive inputs, take one rising edge, advance the model, compare 1 ns later.
  task automatic step(input logic v_en, input logic v_valid, input logic [WS-1:0] v_samp);
    en           = v_en;
    bus.in_valid = v_valid;
    bus.in_samp  = v_samp;
    @(posedge clk);
    m_edge(v_en, v_valid, v_samp);
    #1;
    check_all();
  endtask

  int wr_cnt;

  initial begin
    reset_n      = 1'b0;
    en           = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_samp  = '0;
    m_reset();
    #12;
    check_all();
    reset_n = 1'b1;

    // Back-to-back load of 10..17, then input held valid in DONE.
    step(1, 0, 0);
    wr_cnt = 0;
    for (int i = 0; i < N; i++) begin
      step(1, 1, WS'(10 + i));
      if (bus.wr_en) wr_cnt++;
    end
    chk("first_load_pulses", 32'(wr_cnt), 32'(N / 2));
    chk("done_after_load", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 16'h99);
    step(0, 0, 0);

    // Gapped input: valid 1,0,0 pattern.
    step(1, 0, 0);
    for (int i = 0; i < N; i++) begin
      step(1, 1, WS'(20 + i));
      if (i < N - 1) begin
        step(1, 0, WS'($urandom));
        step(1, 0, WS'($urandom));
      end
    end
    step(0, 0, 0);

    // Abort after three samples; en low wins over a simultaneous valid.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, WS'(30 + i));
    step(0, 1, 16'h33);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < N; i++) step(1, 1, WS'(40 + i));
    step(0, 0, 0);

    // Asynchronous reset between edges mid-load.
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, WS'(50 + i));
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all();
    step(1, 1, 16'h77);
    #2;
    reset_n = 1'b1;
    step(1, 0, 0);
    for (int i = 0; i < N; i++) step(1, 1, WS'(60 + i));
    step(0, 0, 0);

    // Random traffic with occasional aborts.
    for (int i = 0; i < 2000; i++)
      step(($urandom % 20) != 0, ($urandom % 2) == 1, WS'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
